mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port, synchronous on-chip program/data memory (64 x 16) between two requesters.
- Requester 0 is the processor core; requester 1 is the board-level debug/inspector port (switch-selected address, value shown on HEX).
- Serialises requests, drives the memory port and returns registered read data with a done pulse.
- Sits inside top, between the requesters and the memory instance.

Parameters:
ADDR_WIDTH, 6, memory address width
DATA_WIDTH, 16, memory word width

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 request; held until done0
we0  in  1  requester 0 write enable (1 = write, 0 = read)
addr0  in  ADDR_WIDTH  requester 0 address
wdata0  in  DATA_WIDTH  requester 0 write data
gnt0  out  1  requester 0 owns the memory
done0  out  1  one-cycle completion pulse for requester 0
req1, we1, addr1, wdata1, gnt1, done1  same as above for requester 1
rdata  out  DATA_WIDTH  registered read data; valid when done0 or done1 is high after a read
mem_addr  out  ADDR_WIDTH  memory address
mem_we  out  1  memory write strobe
mem_wdata  out  DATA_WIDTH  memory write data
mem_q  in  DATA_WIDTH  memory read data, valid one cycle after mem_addr

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE.
  - gnt0, gnt1, done0, done1, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - Last-grant pointer = 1, so requester 0 wins the first tie.
- FSM states:
  - IDLE: if no req, stay. Otherwise select a winner: a single requester wins outright; if both request, the one not granted last wins. Latch the winner id, we, addr and wdata. Go to ISSUE.
  - ISSUE: drive mem_addr and mem_wdata from the latches. mem_we = latched we for exactly this cycle. gnt(winner) = 1. Go to CAPTURE.
  - CAPTURE: mem_we = 0. On a read, register mem_q into rdata; on a write, rdata holds. gnt stays high. Go to DONE.
  - DONE: done(winner) = 1 for one cycle; gnt stays high. Update the last-grant pointer to the winner. Go to IDLE.
- Latency: request sampled in IDLE at cycle T → mem access at T+1 → capture at T+2 → done at T+3. Fixed 4 cycles per transaction, reads and writes alike. Maximum throughput is 1 transaction per 4 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until done.
  - Drop req or start a new request in the cycle after done.
  - If req is still high in the IDLE cycle after done, it is a new request.
- Request inputs change while not granted: no effect. Values are sampled only in IDLE.
- Simultaneous req0/req1 in IDLE: round-robin as above. No starvation; alternating grants while both are held.
- gnt0 and gnt1 are never high together. done is only asserted while the matching gnt is high.
- rst mid-transaction (any state): next edge returns to IDLE with all reset values. No done pulse is emitted and the pointer resets. A write whose ISSUE cycle already completed remains in memory.
- rdata changes only in CAPTURE of a read; otherwise it holds its last value.

Optional Feature:
- Macro MEM_ARBITER_FIXED_PRIO_EN.
- Defined: strict priority. Requester 0 always wins a tie; the pointer is not implemented. Requester 1 can starve while req0 is held.
- Undefined (default): round-robin as specified in Behaviour.

Decomposition:
- Package mem_arb_pkg:
  - State enum (IDLE, ISSUE, CAPTURE, DONE).
  - Requester count constant NUM_REQ = 2.
  - Requester id constants REQ_CPU = 0, REQ_DBG = 1.
- Sub-module rr_pick2: combinational 2-way picker. Inputs: req vector, last-grant pointer. Outputs: winner id, valid. It also contains the fixed-priority variant under the macro.

Test Plan:
- Reset, then req0 read addr 6'h05 with memory[5] = 16'hBEEF → gnt0 high cycles T+1..T+3; mem_we stays 0; done0 at T+3 with rdata = 16'hBEEF.
- req1 write addr 6'h3F, wdata 16'h1234 → mem_we high only at T+1 with mem_addr = 6'h3F, mem_wdata = 16'h1234; done1 at T+3. A following req0 read of 6'h3F returns 16'h1234.
- req0 and req1 asserted together at reset release, both held for 4 transactions → grant order 0,1,0,1. Each done is 4 cycles apart; gnt0 and gnt1 are never high together.
- With MEM_ARBITER_FIXED_PRIO_EN, the same stimulus → grant order 0,0,0,0. req1 is served only after req0 drops.
- rst asserted during CAPTURE of a read → next cycle state IDLE, gnt and done low, rdata = 0. No done pulse follows.
- req1 read with addr changed during IDLE-to-ISSUE (addr1 toggles 6'h01→6'h02 after sampling) → mem_addr = 6'h01 (latched value). rdata = memory[1].

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int   NUM_REQ = 2;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way winner picker: round-robin on the last-grant pointer, or
// strict requester-0 priority when MEM_ARBITER_FIXED_PRIO_EN is defined.
module rr_pick2 import mem_arb_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic               win,
    output logic               valid
);

    assign valid = |req;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    assign win = req[REQ_DBG] & ~req[REQ_CPU];
`else
    // On a tie the requester not served last wins.
    assign win = (req[REQ_CPU] & req[REQ_DBG]) ? ~last : req[REQ_DBG];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and debug-port accesses onto the single-port 64x16 memory.
// Optional macro MEM_ARBITER_FIXED_PRIO_EN: strict CPU priority, no pointer.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  done0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    state_t state;
    logic   win_id;
    logic   lat_we;
    logic   last_gnt;
    logic   pick_win;
    logic   pick_vld;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last_gnt),
        .win   (pick_win),
        .valid (pick_vld)
    );

`ifdef MEM_ARBITER_FIXED_PRIO_EN
    assign last_gnt = REQ_DBG;
`else
    always_ff @(posedge clk) begin
        if (rst)
            last_gnt <= REQ_DBG;
        else if (state == DONE)
            last_gnt <= win_id;
    end
`endif

    // mem_addr/mem_wdata double as the request latches for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            win_id    <= REQ_CPU;
            lat_we    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        win_id    <= pick_win;
                        lat_we    <= pick_win ? we1 : we0;
                        mem_we    <= pick_win ? we1 : we0;
                        mem_addr  <= pick_win ? addr1 : addr0;
                        mem_wdata <= pick_win ? wdata1 : wdata0;
                        gnt0      <= ~pick_win;
                        gnt1      <= pick_win;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (!lat_we)
                        rdata <= mem_q;
                    done0 <= (win_id == REQ_CPU);
                    done1 <= (win_id == REQ_DBG);
                    state <= DONE;
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
